cabac_byte_writer: RTL and testbench

//  Output byte stage of the VVC CABAC arithmetic encoder; inverse of the decoder's byte-read path.

---
 rtl/cabac_enc_pkg.sv | 22 ++
 rtl/cabac_byte_writer_if.sv | 25 ++
 rtl/cabac_byte_writer.sv | 153 +++++++++++++++
 tb/tb_cabac_byte_writer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cabac_enc_pkg.sv
// Shared types and constants for the CABAC output byte stage.
// The EMIT_EPB state is only reachable when CABAC_EPB_EN is defined.
package cabac_enc_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EMIT_BUF = 3'd1,
    EMIT_RUN = 3'd2,
    EMIT_EPB = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [8:0] LEAD_FF  = 9'h0FF;
  localparam logic [7:0] BUF_RST  = 8'hFF;
  localparam logic [7:0] EPB_BYTE = 8'h03;

  // Two zero bytes already out and the next byte would form a start-code prefix.
  function automatic logic needs_epb(input logic [1:0] zero_cnt, input logic [7:0] b);
    return (zero_cnt == 2'd2) && (b <= 8'h03);
  endfunction

endpackage

// File: rtl/cabac_byte_writer_if.sv
// Lead-byte input stream, flush control and bitstream output stream of the byte writer.
// Handshakes: a transfer happens on a rising edge where valid & ready are both high;
// valid and its payload stay stable until that edge, and ready never depends on valid.
interface cabac_byte_writer_if;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] lead_byte;
  logic       flush_req;
  logic       flush_carry;
  logic       flush_done;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_byte;
  logic       ovf;

  modport master (
    output in_valid, lead_byte, flush_req, flush_carry, out_ready,
    input  in_ready, flush_done, out_valid, out_byte, ovf
  );

  modport slave (
    input  in_valid, lead_byte, flush_req, flush_carry, out_ready,
    output in_ready, flush_done, out_valid, out_byte, ovf
  );
endinterface

// File: rtl/cabac_byte_writer.sv
// CABAC output byte stage: holds one buffered byte plus a run of 0xFF bytes until the carry
// is known, then emits them. Optional emulation prevention under `define CABAC_EPB_EN.
module cabac_byte_writer
  import cabac_enc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  cabac_byte_writer_if.slave   bus,
  output state_t               o_dbg_state,
  output logic [CNT_W-1:0]     o_dbg_num_buf,
  output logic [7:0]           o_dbg_buf
);

  state_t           r_state, w_next_state;
  logic             r_in_ready;
  logic [7:0]       r_buf;
  logic [CNT_W-1:0] r_num;
  logic             r_carry;
  logic [CNT_W-1:0] r_run_left;
  logic             r_flush;
  logic             r_ovf;
  logic [7:0]       r_out_byte;

  logic       w_accept, w_flush_acc, w_is_ff, w_carry, w_start;
  logic       w_hs, w_emit, w_more;
  logic [7:0] w_first_byte, w_run_byte;

  assign w_accept     = bus.in_valid & r_in_ready;
  assign w_flush_acc  = bus.flush_req & ~bus.in_valid & r_in_ready;
  assign w_is_ff      = (bus.lead_byte == LEAD_FF);
  assign w_carry      = w_accept ? bus.lead_byte[8] : bus.flush_carry;
  assign w_start      = ((w_accept & ~w_is_ff) | w_flush_acc) & (r_num != '0);
  // The carry lands in the buffered byte; the 0xFF run absorbs it as 0x00 without rippling.
  assign w_first_byte = r_buf + {7'b0, w_carry};
  assign w_run_byte   = BUF_RST + {7'b0, r_carry};
  assign w_hs         = bus.out_valid & bus.out_ready;
  assign w_emit       = (r_state == EMIT_BUF) || (r_state == EMIT_RUN);
  assign w_more       = (r_run_left != '0);

`ifdef CABAC_EPB_EN
  logic [1:0] r_zero_cnt;
  state_t     r_epb_ret;
  logic [1:0] w_zc_after;
  logic       w_epb_first, w_epb_run;

  always_comb begin
    w_zc_after = 2'd0;
    if (r_state != EMIT_EPB && r_out_byte == 8'h00)
      w_zc_after = (r_zero_cnt == 2'd2) ? 2'd2 : r_zero_cnt + 2'd1;
  end
  assign w_epb_first  = needs_epb(r_zero_cnt, w_first_byte);
  assign w_epb_run    = needs_epb(w_zc_after, w_run_byte);
  assign bus.out_byte = (r_state == EMIT_EPB) ? EPB_BYTE : r_out_byte;
  assign bus.out_valid = w_emit || (r_state == EMIT_EPB);
`else
  assign bus.out_byte  = r_out_byte;
  assign bus.out_valid = w_emit;
`endif

  assign bus.in_ready   = r_in_ready;
  assign bus.flush_done = (r_state == DONE);
  assign bus.ovf        = r_ovf;
  assign o_dbg_state    = r_state;
  assign o_dbg_num_buf  = r_num;
  assign o_dbg_buf      = r_buf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
`ifdef CABAC_EPB_EN
        if (w_start)          w_next_state = w_epb_first ? EMIT_EPB : EMIT_BUF;
`else
        if (w_start)          w_next_state = EMIT_BUF;
`endif
        else if (w_flush_acc) w_next_state = DONE;
      end
      EMIT_BUF, EMIT_RUN: begin
        if (w_hs) begin
`ifdef CABAC_EPB_EN
          if (w_more) w_next_state = w_epb_run ? EMIT_EPB : EMIT_RUN;
`else
          if (w_more) w_next_state = EMIT_RUN;
`endif
          else        w_next_state = r_flush ? DONE : IDLE;
        end
      end
`ifdef CABAC_EPB_EN
      EMIT_EPB: if (w_hs) w_next_state = r_epb_ret;
`endif
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_ready <= 1'b0;
      r_buf      <= BUF_RST;
      r_num      <= '0;
      r_carry    <= 1'b0;
      r_run_left <= '0;
      r_flush    <= 1'b0;
      r_ovf      <= 1'b0;
      r_out_byte <= 8'h00;
`ifdef CABAC_EPB_EN
      r_zero_cnt <= 2'd0;
      r_epb_ret  <= EMIT_BUF;
`endif
    end else begin
      r_in_ready <= (w_next_state == IDLE);
      if (w_accept) begin
        if (w_is_ff) begin
          if (r_num == '1) r_ovf <= 1'b1;
          else             r_num <= r_num + CNT_W'(1);
        end else begin
          r_buf <= bus.lead_byte[7:0];
          r_num <= CNT_W'(1);
        end
      end else if (w_flush_acc) begin
        r_buf <= BUF_RST;
        r_num <= '0;
      end
      if (w_accept || w_flush_acc) r_flush <= w_flush_acc;
      if (w_start) begin
        r_carry    <= w_carry;
        r_run_left <= r_num - CNT_W'(1);
        r_out_byte <= w_first_byte;
`ifdef CABAC_EPB_EN
        r_epb_ret  <= EMIT_BUF;
`endif
      end else if (w_emit && w_hs && w_more) begin
        r_run_left <= r_run_left - CNT_W'(1);
        r_out_byte <= w_run_byte;
`ifdef CABAC_EPB_EN
        r_epb_ret  <= EMIT_RUN;
`endif
      end
      if (r_state == DONE) r_flush <= 1'b0;
`ifdef CABAC_EPB_EN
      if (w_hs) r_zero_cnt <= w_zc_after;
`endif
    end
  end

endmodule

// File: tb/tb_cabac_byte_writer.sv
// Directed bench for cabac_byte_writer: main instance (CNT_W=16) plus a CNT_W=2 instance
// for counter saturation. Expected bytes follow CABAC_EPB_EN when it is defined.
module tb_cabac_byte_writer;
  import cabac_enc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cabac_byte_writer_if u_if ();
  cabac_byte_writer_if b_if ();

  state_t      dbg_state, b_state;
  logic [15:0] dbg_num;
  logic [1:0]  b_num;
  logic [7:0]  dbg_buf, b_buf;

  cabac_byte_writer #(.CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .bus(u_if),
    .o_dbg_state(dbg_state), .o_dbg_num_buf(dbg_num), .o_dbg_buf(dbg_buf)
  );

  cabac_byte_writer #(.CNT_W(2)) u_dut_sat (
    .clk(clk), .rst(rst), .bus(b_if),
    .o_dbg_state(b_state), .o_dbg_num_buf(b_num), .o_dbg_buf(b_buf)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int hs_t = 0;
  int done_t = 0;
  int done_n = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: samples on the falling edge, between input updates and active edges.
  always @(negedge clk) begin
    if (!rst) begin
      if (u_if.out_valid && u_if.out_ready) begin
        got_q.push_back(u_if.out_byte);
        hs_t = cyc;
      end
      if (u_if.flush_done) begin
        done_n++;
        done_t = cyc;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    u_if.in_valid = 1'b0; u_if.lead_byte = 9'h000; u_if.flush_req = 1'b0;
    u_if.flush_carry = 1'b0; u_if.out_ready = 1'b1;
    b_if.in_valid = 1'b0; b_if.lead_byte = 9'h000; b_if.flush_req = 1'b0;
    b_if.flush_carry = 1'b0; b_if.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    got_q.delete();
    done_n = 0;
  endtask

  task automatic send_lead(input logic [8:0] l);
    int n = 0;
    while (!u_if.in_ready && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("in_ready_timeout", 32'(u_if.in_ready), 32'd1);
    u_if.in_valid  = 1'b1;
    u_if.lead_byte = l;
    tick();
    u_if.in_valid  = 1'b0;
  endtask

  task automatic do_flush(input logic c, input string tag);
    int n = 0;
    while (!u_if.in_ready && n < 200) begin
      tick();
      n++;
    end
    u_if.flush_req   = 1'b1;
    u_if.flush_carry = c;
    tick();
    u_if.flush_req   = 1'b0;
    n = 0;
    while (done_n == 0 && n < 100) begin
      tick();
      n++;
    end
    repeat (3) tick();
    chk({tag, "_done_pulses"}, 32'(done_n), 32'd1);
  endtask

  task automatic check_bytes(input string tag);
    chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) chk($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
  endtask

  initial begin
    u_if.in_valid = 1'b0; u_if.lead_byte = 9'h000; u_if.flush_req = 1'b0;
    u_if.flush_carry = 1'b0; u_if.out_ready = 1'b1;
    b_if.in_valid = 1'b0; b_if.lead_byte = 9'h000; b_if.flush_req = 1'b0;
    b_if.flush_carry = 1'b0; b_if.out_ready = 1'b1;

    // Reset values while rst is held
    rst = 1'b1;
    tick();
    tick();
    chk("rst_in_ready", 32'(u_if.in_ready), 32'd0);
    chk("rst_out_valid", 32'(u_if.out_valid), 32'd0);
    chk("rst_out_byte", 32'(u_if.out_byte), 32'h00);
    chk("rst_flush_done", 32'(u_if.flush_done), 32'd0);
    chk("rst_ovf", 32'(u_if.ovf), 32'd0);
    chk("rst_buf", 32'(dbg_buf), 32'hFF);
    chk("rst_num_buf", 32'(dbg_num), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(IDLE));
    chk("rst_sat_ovf", 32'(b_if.ovf), 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(u_if.in_ready), 32'd1);

    // 1: two plain leads then flush with carry 0
    do_reset();
    send_lead(9'h012);
    chk("t1_no_out_first", 32'(u_if.out_valid), 32'd0);
    send_lead(9'h034);
    chk("t1_latency_valid", 32'(u_if.out_valid), 32'd1);
    chk("t1_latency_byte", 32'(u_if.out_byte), 32'h12);
    chk("t1_busy_in_ready", 32'(u_if.in_ready), 32'd0);
    do_flush(1'b0, "t1");
    exp_q = '{8'h12, 8'h34};
    check_bytes("t1");
    chk("t1_done_after_hs", 32'(done_t - hs_t), 32'd1);
    chk("t1_buf_after", 32'(dbg_buf), 32'hFF);
    chk("t1_num_after", 32'(dbg_num), 32'd0);

    // 2: carry into buffered byte, run of 0xFF becomes 0x00
    do_reset();
    send_lead(9'h080);
    send_lead(9'h0FF);
    send_lead(9'h0FF);
    send_lead(9'h105);
    repeat (10) tick();
    exp_q = '{8'h81, 8'h00, 8'h00};
    check_bytes("t2");
    chk("t2_buf", 32'(dbg_buf), 32'h05);
    chk("t2_num", 32'(dbg_num), 32'd1);

    // 3: no carry, run stays 0xFF; flush with carry 1
    do_reset();
    send_lead(9'h080);
    send_lead(9'h0FF);
    send_lead(9'h0FF);
    send_lead(9'h005);
    repeat (10) tick();
    exp_q = '{8'h80, 8'hFF, 8'hFF};
    check_bytes("t3_pre");
    do_flush(1'b1, "t3");
    exp_q = '{8'h80, 8'hFF, 8'hFF, 8'h06};
    check_bytes("t3");
    chk("t3_num_after", 32'(dbg_num), 32'd0);

    // 4: back-pressure on the buffered byte and mid-run
    do_reset();
    send_lead(9'h080);
    send_lead(9'h0FF);
    send_lead(9'h0FF);
    send_lead(9'h0FF);
    u_if.out_ready = 1'b0;
    send_lead(9'h105);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold_valid", 32'(u_if.out_valid), 32'd1);
      chk("t4_hold_byte", 32'(u_if.out_byte), 32'h81);
      chk("t4_hold_in_ready", 32'(u_if.in_ready), 32'd0);
    end
    u_if.out_ready = 1'b1;
    tick();
    u_if.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_run_in_ready", 32'(u_if.in_ready), 32'd0);
      chk("t4_run_count", 32'(got_q.size()), 32'd1);
    end
    u_if.out_ready = 1'b1;
    repeat (10) tick();
    exp_q = '{8'h81, 8'h00, 8'h00, 8'h00};
    check_bytes("t4");

    // 5: CNT_W=2 counter saturation
    do_reset();
    b_if.in_valid = 1'b1;
    b_if.lead_byte = 9'h001;
    tick();
    b_if.lead_byte = 9'h0FF;
    tick();
    tick();
    chk("t5_num_pre", 32'(b_num), 32'd3);
    chk("t5_ovf_pre", 32'(b_if.ovf), 32'd0);
    tick();
    tick();
    b_if.in_valid = 1'b0;
    tick();
    tick();
    chk("t5_ovf", 32'(b_if.ovf), 32'd1);
    chk("t5_num_held", 32'(b_num), 32'd3);
    chk("t5_no_out", 32'(b_if.out_valid), 32'd0);
    chk("t5_main_ovf", 32'(u_if.ovf), 32'd0);

    // 6: zero bytes followed by a small byte
    do_reset();
    send_lead(9'h000);
    send_lead(9'h000);
    send_lead(9'h001);
    do_flush(1'b0, "t6");
`ifdef CABAC_EPB_EN
    exp_q = '{8'h00, 8'h00, 8'h03, 8'h01};
`else
    exp_q = '{8'h00, 8'h00, 8'h01};
`endif
    check_bytes("t6");

    // 7: reset in the middle of a run aborts it
    do_reset();
    send_lead(9'h080);
    send_lead(9'h0FF);
    send_lead(9'h0FF);
    send_lead(9'h0FF);
    send_lead(9'h105);
    tick();
    chk("t7_in_run", 32'(dbg_state), 32'(EMIT_RUN));
    #1 rst = 1'b1;
    #1;
    chk("t7_rst_out_valid", 32'(u_if.out_valid), 32'd0);
    chk("t7_rst_num", 32'(dbg_num), 32'd0);
    chk("t7_rst_buf", 32'(dbg_buf), 32'hFF);
    #1 rst = 1'b0;
    tick();
    got_q.delete();
    done_n = 0;
    send_lead(9'h022);
    do_flush(1'b0, "t7");
    exp_q = '{8'h22};
    check_bytes("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
